// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side consumers.
package fifo_pkg;

  localparam int FIFO_DATASIZE     = 8;
  localparam int FIFO_ADDRESS_BITS = 4;
  localparam int PACK_RATIO_MAX    = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  // Lane-valid mask for a partial beat holding cnt words: (1<<cnt)-1.
  // Sized for the largest legal pack ratio; callers truncate to their width.
  function automatic logic [PACK_RATIO_MAX-1:0] keep_mask(input logic [4:0] cnt);
    logic [PACK_RATIO_MAX:0] w_one;
    w_one = {{PACK_RATIO_MAX{1'b0}}, 1'b1} << cnt;
    return PACK_RATIO_MAX'(w_one - 1'b1);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready output register. Loads a new payload when asked, holds it
// while the consumer stalls, and drops valid once the payload is taken.
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load has priority; otherwise an accepted payload clears valid and a
  // stalled one simply holds. The owner only loads when the slot is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops FWFT FIFO words and packs PACK_RATIO of them,
// lane 0 first, into one wide valid/ready beat. A flush closes out a
// partially filled beat with a keep mask.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATASIZE   = FIFO_DATASIZE,
  parameter int PACK_RATIO = 4
) (
  input  logic                           read_clk,
  input  logic                           read_rst,
  input  logic [DATASIZE-1:0]            read_data,
  input  logic                           rempty,
  output logic                           read_inc,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATASIZE*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]          out_keep
);

  localparam int              CW   = $clog2(PACK_RATIO);
  localparam int              BW   = DATASIZE * PACK_RATIO;
  localparam logic [CW-1:0]   LAST = CW'(PACK_RATIO - 1);

  pack_state_t                r_state;
  logic [CW-1:0]              r_cnt;
  logic                       r_flush_done;

  logic                       w_out_free;
  logic                       w_last;
  logic                       w_pop;
  logic                       w_load_full;
  logic                       w_load_part;
  logic                       w_load;
  logic [PACK_RATIO-1:0]      w_keep;
  logic [BW-1:0]              w_full_data;
  logic [BW-1:0]              w_part_data;
  logic [BW+PACK_RATIO-1:0]   w_load_beat;
  logic [BW+PACK_RATIO-1:0]   w_beat;

  // The output slot can take a new beat if it is empty or being drained now.
  assign w_out_free = !out_valid || out_ready;
  assign w_last     = (r_cnt == LAST);

  // Filling the last lane needs a free output slot, the other lanes only
  // need a word; no pops at all while a flush is pending or in reset.
  assign read_inc = read_rst && !rempty && (r_state == RUN) && (!w_last || w_out_free);
  assign w_pop    = read_inc;

  assign w_keep = PACK_RATIO'(keep_mask(5'(r_cnt)));

  // Accumulator: one register per lane except the last, whose word is taken
  // straight from read_data on the completing pop.
  genvar gi;
  for (gi = 0; gi < PACK_RATIO - 1; gi++) begin : g_lane
    logic [DATASIZE-1:0] r_lane;

    // Capture the popped word when the counter points at this lane.
    always_ff @(posedge read_clk) begin
      if (!read_rst) begin
        r_lane <= '0;
      end else if (w_pop && !w_last && (r_cnt == CW'(gi))) begin
        r_lane <= read_data;
      end
    end

    assign w_full_data[gi*DATASIZE +: DATASIZE] = r_lane;
    // Lanes beyond the fill level may hold stale words; zero them.
    assign w_part_data[gi*DATASIZE +: DATASIZE] = w_keep[gi] ? r_lane : '0;
  end

  assign w_full_data[BW-1 -: DATASIZE] = read_data;
  // A partial beat never reaches the last lane.
  assign w_part_data[BW-1 -: DATASIZE] = '0;

  assign w_load_full = w_pop && w_last;
  assign w_load_part = (r_state == FLUSH) && (r_cnt != '0) && w_out_free;
  assign w_load      = w_load_full || w_load_part;
  assign w_load_beat = w_load_full ? {{PACK_RATIO{1'b1}}, w_full_data}
                                   : {w_keep, w_part_data};

  stream_out_reg #(
    .WIDTH (BW + PACK_RATIO)
  ) u_out_reg (
    .clk     (read_clk),
    .rst_n   (read_rst),
    .i_load  (w_load),
    .i_data  (w_load_beat),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (w_beat)
  );

  assign out_data   = w_beat[BW-1:0];
  assign out_keep   = w_beat[BW +: PACK_RATIO];
  assign flush_done = r_flush_done;

  // Control FSM: lane counter advance in RUN, partial-beat close-out in FLUSH.
  always_ff @(posedge read_clk) begin
    if (!read_rst) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_pop) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          end
          // A pop in this same cycle still lands and is part of the flush.
          if (flush_req) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          // Nothing buffered, or the slot is free for the partial beat.
          if ((r_cnt == '0) || w_out_free) begin
            r_cnt        <= '0;
            r_flush_done <= 1'b1;
            r_state      <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DATASIZE=8, PACK_RATIO=4) driven by a
// small FWFT FIFO model; accepted beats are logged and compared to
// hand-computed values.
module tb_fifo_rd_packer;

  logic        read_clk = 1'b0;
  logic        read_rst;
  logic [7:0]  read_data;
  logic        rempty;
  logic        read_inc;
  logic        flush_req;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          pops     = 0;
  logic [7:0]  q[$];
  logic [35:0] beats[$];
  int          beat_cyc[$];

  fifo_rd_packer #(
    .DATASIZE   (8),
    .PACK_RATIO (4)
  ) dut (
    .read_clk   (read_clk),
    .read_rst   (read_rst),
    .read_data  (read_data),
    .rempty     (rempty),
    .read_inc   (read_inc),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep)
  );

  always #5 read_clk = ~read_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    rempty    = (q.size() == 0);
    read_data = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: present the FIFO head, sample read_inc and the output
  // handshake before the edge, pop the model on the edge, return at negedge.
  task automatic tick(output logic inc);
    logic [7:0] dummy;
    refresh();
    #1;
    inc = read_inc;
    if (out_valid && out_ready) begin
      beats.push_back({out_keep, out_data});
      beat_cyc.push_back(cyc);
      $display("beat cyc=%0d keep=%b data=0x%08h", cyc, out_keep, out_data);
    end
    @(posedge read_clk);
    if (inc && q.size() != 0) begin
      dummy = q.pop_front();
      pops++;
    end
    cyc++;
    @(negedge read_clk);
    refresh();
  endtask

  task automatic ticks(input int n);
    logic inc;
    for (int i = 0; i < n; i++) tick(inc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        inc;
    logic [35:0] b;
    logic [31:0] exp_stream [4];
    exp_stream = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

    read_rst  = 1'b0;
    out_ready = 1'b1;
    flush_req = 1'b0;
    q.push_back(8'h11);
    refresh();
    @(negedge read_clk);

    // Reset: no pop even with data at the FIFO head
    tick(inc);
    chk("rst_read_inc", inc, 0);
    tick(inc);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flush_done", flush_done, 0);

    // Basic pack
    q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    read_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(inc);
      chk($sformatf("basic_inc%0d", i), inc, 1);
    end
    chk("basic_valid", out_valid, 1);
    chk("basic_data", out_data, 32'h44332211);
    chk("basic_keep", out_keep, 4'hF);
    tick(inc);
    chk("basic_cleared", out_valid, 0);
    chk("basic_nbeats", beats.size(), 1);
    beats.delete(); beat_cyc.delete();

    // Streaming: 16 bytes, always ready
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    pops = 0;
    ticks(16);
    chk("stream_pops", pops, 16);
    ticks(4);
    chk("stream_nbeats", beats.size(), 4);
    for (int i = 0; i < 4; i++) begin
      b = (i < beats.size()) ? beats[i] : 36'h0;
      chk($sformatf("stream_data%0d", i), b[31:0], exp_stream[i]);
      chk($sformatf("stream_keep%0d", i), b[35:32], 4'hF);
      if (i > 0 && i < beat_cyc.size())
        chk($sformatf("stream_gap%0d", i), beat_cyc[i] - beat_cyc[i-1], 4);
    end
    beats.delete(); beat_cyc.delete();

    // Backpressure: 8 bytes, downstream stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back(8'h10 + 8'(i));
    pops = 0;
    for (int i = 0; i < 10; i++) tick(inc);
    chk("bp_pops", pops, 7);
    chk("bp_stalled_inc", inc, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_held_data", out_data, 32'h13121110);
    chk("bp_no_beats", beats.size(), 0);
    out_ready = 1'b1;
    ticks(3);
    chk("bp_pops_total", pops, 8);
    chk("bp_nbeats", beats.size(), 2);
    b = (beats.size() > 0) ? beats[0] : 36'h0;
    chk("bp_beat0", b, {4'hF, 32'h13121110});
    b = (beats.size() > 1) ? beats[1] : 36'h0;
    chk("bp_beat1", b, {4'hF, 32'h17161514});
    beats.delete(); beat_cyc.delete();

    // Partial flush, flush_req coincident with the second pop
    q.push_back(8'hAA); q.push_back(8'hBB);
    tick(inc);
    flush_req = 1'b1;
    tick(inc);
    flush_req = 1'b0;
    chk("pf_pop_with_req", inc, 1);
    chk("pf_done_early", flush_done, 0);
    tick(inc);
    chk("pf_valid", out_valid, 1);
    chk("pf_data", out_data, 32'h0000BBAA);
    chk("pf_keep", out_keep, 4'b0011);
    chk("pf_done", flush_done, 1);
    tick(inc);
    chk("pf_done_pulse", flush_done, 0);
    chk("pf_nbeats", beats.size(), 1);

    // Flush with nothing buffered
    flush_req = 1'b1;
    tick(inc);
    flush_req = 1'b0;
    tick(inc);
    chk("zf_done", flush_done, 1);
    chk("zf_no_valid", out_valid, 0);
    tick(inc);
    chk("zf_nbeats", beats.size(), 1);
    beats.delete(); beat_cyc.delete();

    // Flush under backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) q.push_back(8'h20 + 8'(i));
    ticks(6);
    flush_req = 1'b1;
    tick(inc);
    flush_req = 1'b0;
    q.push_back(8'h26);
    tick(inc);
    chk("fbp_inc_a", inc, 0);
    tick(inc);
    chk("fbp_inc_b", inc, 0);
    chk("fbp_no_done", flush_done, 0);
    chk("fbp_held", out_data, 32'h23222120);
    out_ready = 1'b1;
    tick(inc);
    chk("fbp_inc_c", inc, 0);
    chk("fbp_done", flush_done, 1);
    chk("fbp_part_data", out_data, 32'h00002524);
    chk("fbp_part_keep", out_keep, 4'b0011);
    tick(inc);
    chk("fbp_resume_inc", inc, 1);
    chk("fbp_nbeats", beats.size(), 2);
    b = (beats.size() > 0) ? beats[0] : 36'h0;
    chk("fbp_beat0", b, {4'hF, 32'h23222120});
    b = (beats.size() > 1) ? beats[1] : 36'h0;
    chk("fbp_beat1", b, {4'b0011, 32'h00002524});
    beats.delete(); beat_cyc.delete();

    // Reset mid-operation: lane 0 already holds 0x26
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) q.push_back(8'h30 + 8'(i));
    ticks(5);
    chk("mr_held_valid", out_valid, 1);
    chk("mr_held_data", out_data, 32'h32313026);
    read_rst = 1'b0;
    q.push_back(8'h35);
    tick(inc);
    chk("mr_inc", inc, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_keep", out_keep, 0);
    chk("mr_data", out_data, 0);
    chk("mr_done", flush_done, 0);
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'h40 + 8'(i));
    read_rst  = 1'b1;
    out_ready = 1'b1;
    ticks(4);
    chk("mr_fresh_valid", out_valid, 1);
    chk("mr_fresh_data", out_data, 32'h43424140);
    chk("mr_fresh_keep", out_keep, 4'hF);
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
